// File: rtl/ascon_pkg.sv
// Shared types and sizes for the byte-serial Ascon state front/back end.
package ascon_pkg;

  localparam int STATE_BYTES = 40;
  localparam int WORD_W      = 64;
  localparam int STATE_W     = 320;

  typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_e;

  // Update selector for the 320-bit state register
  typedef enum logic [1:0] {SH_HOLD, SH_LOAD, SH_CAPTURE, SH_ROTATE} sh_op_e;

endpackage

// File: rtl/ascon_state_shreg.sv
// 320-bit Ascon state register: byte shift-in, permutation capture and byte rotate.
// ASCON_BYTE_IO_XOR_EN turns the shift-in into a sponge absorb (byte XORed into retained state).
module ascon_state_shreg
  import ascon_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  sh_op_e             op,
  input  logic [7:0]         in_byte,
  input  logic [STATE_W-1:0] cap,
  output logic [STATE_W-1:0] sh,
  output logic [7:0]         top_byte
);

  logic [STATE_W-1:0] sh_q;
  logic [STATE_W-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    case (op)
`ifdef ASCON_BYTE_IO_XOR_EN
      SH_LOAD:    sh_d = {sh_q[STATE_W-9:0], sh_q[STATE_W-1 -: 8] ^ in_byte};
`else
      SH_LOAD:    sh_d = {sh_q[STATE_W-9:0], in_byte};
`endif
      SH_CAPTURE: sh_d = cap;
      SH_ROTATE:  sh_d = {sh_q[STATE_W-9:0], sh_q[STATE_W-1 -: 8]};
      default:    sh_d = sh_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign sh       = sh_q;
  assign top_byte = sh_q[STATE_W-1 -: 8];

endmodule

// File: rtl/ascon_byte_io.sv
// Byte-serial load/unload wrapper around the asconp permutation core.
// Optional sponge absorb on load is selected by ASCON_BYTE_IO_XOR_EN (default: plain overwrite).
module ascon_byte_io #(
  parameter int STATE_BYTES = 40,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        perm_start,
  input  logic        perm_done,
  output logic [63:0] S_0,
  output logic [63:0] S_1,
  output logic [63:0] S_2,
  output logic [63:0] S_3,
  output logic [63:0] S_4,
  input  logic [63:0] S_0_in,
  input  logic [63:0] S_1_in,
  input  logic [63:0] S_2_in,
  input  logic [63:0] S_3_in,
  input  logic [63:0] S_4_in,
  output logic        busy
);

  import ascon_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STATE_BYTES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               perm_start_q, perm_start_d;
  logic               busy_q, busy_d;
  sh_op_e             sh_op;
  logic [STATE_W-1:0] sh;
  logic               in_fire;
  logic               out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_op   = SH_HOLD;
    case (state_q)
      LOAD: begin
        if (in_fire) begin
          sh_op = SH_LOAD;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      START: state_d = WAIT;
      // perm_done is only honoured here, never in START
      WAIT: begin
        if (perm_done) begin
          sh_op   = SH_CAPTURE;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        if (out_fire) begin
          sh_op = SH_ROTATE;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // Outputs are registered versions of the next-state decode
    in_ready_d   = (state_d == LOAD);
    out_valid_d  = (state_d == UNLOAD);
    perm_start_d = (state_d == START);
    busy_d       = (state_d == START) || (state_d == WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      perm_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      perm_start_q <= perm_start_d;
      busy_q       <= busy_d;
    end
  end

  ascon_state_shreg u_shreg (
    .clk      (clk),
    .rst      (rst),
    .op       (sh_op),
    .in_byte  (in_data),
    .cap      ({S_0_in, S_1_in, S_2_in, S_3_in, S_4_in}),
    .sh       (sh),
    .top_byte (out_data)
  );

  assign S_0        = sh[319:256];
  assign S_1        = sh[255:192];
  assign S_2        = sh[191:128];
  assign S_3        = sh[127:64];
  assign S_4        = sh[63:0];
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign perm_start = perm_start_q;
  assign busy       = busy_q;

endmodule
